mem_burst_sequencer: RTL and testbench
======================================

Name: mem_burst_sequencer

Overview:
- Multi-cycle access controller directly upstream of the 32-bit data memory.
- Takes one burst request: op, base address, length. Drives the memory's address, write-data, lane-position, write-enable, extra and special controls, one word per cycle.
- On loads, returns read words as a valid-qualified stream to the vector datapath. On stores, accepts write words through a valid/ready handshake.
- Lets the vector unit move LEN consecutive words without per-word control from the decoder.

Parameters:
AW, 17, memory address width
DW, 32, data word width
LW, 8, burst length counter width (max burst 2^LW-1 words)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous active-high reset
START  input  1  request strobe, sampled in IDLE only
OP  input  2  00 vector load, 01 byte-extract load, 10 vector store, 11 byte-lane store
BASE  input  AW  first word address
LEN  input  LW  number of words
LANE  input  2  byte lane for OP 01/11
WVALID  input  1  store word valid
WDATA  input  DW  store word (vector for 10, byte in [7:0] for 11)
WREADY  output  1  store word accepted when WVALID&WREADY
RVALID  output  1  RDATA valid, single-cycle, no backpressure
RDATA  output  DW  load word
BUSY  output  1  burst in progress
DONE  output  1  one-cycle pulse at burst end
M_A  output  AW  memory address
M_WDV  output  DW  memory vector write data
M_WDS  output  DW  memory scalar write data
M_POS  output  2  memory lane position
M_WE  output  1  memory write enable
M_E  output  1  memory extra select
M_S  output  1  memory special select
M_RD  input  DW  memory read data, valid in the cycle its address is driven

Behaviour:
- Reset (async, RST=1): state IDLE. M_WE, M_E, M_S, RVALID, DONE, BUSY, WREADY all 0. M_A, M_WDV, M_WDS, RDATA all 0. M_POS=0. Reset mid-burst aborts immediately: no further writes, no pending RVALID.
- IDLE: START=1 latches OP, BASE, LEN, LANE. LEN=0 -> DONE state, no memory access. Otherwise OP[1]=0 -> LOAD, OP[1]=1 -> STORE. START outside IDLE is ignored.
- Control mapping while BUSY:
  - OP 00: M_E=0, M_S=0.
  - OP 01: M_E=1, M_S=1, M_POS=LANE. Memory returns the byte zero-extended.
  - OP 10: M_E=0, M_S=0.
  - OP 11: M_E=1, M_S=0, M_POS=LANE, M_WDS=WDATA.
  - M_WDV=WDATA for stores.
- LOAD: one address per cycle, M_A=BASE+i for i=0..LEN-1. M_RD is registered into RDATA, so RVALID rises 1 cycle after each address. After the last address, go to DRAIN for 1 cycle (last RVALID), then DONE.
- STORE: WREADY=1 throughout. M_WE=WVALID (combinational). Address and remaining count advance only on accepted beats. WVALID gaps stall the burst without writing. After the last accepted beat, go to DONE.
- DONE: DONE=1 and BUSY=0 for one cycle, then IDLE. A START in the DONE cycle is ignored.
- BUSY=1 in LOAD, DRAIN and STORE.
- Address arithmetic is modulo 2^AW: 0x1FFFF+1 wraps to 0x00000.
- Length counter counts down. Terminal condition is remaining==1 on an issued or accepted beat.

Optional Feature:
- Macro MEM_SEQ_STRIDE_EN.
- When defined: adds input STRIDE[LW-1:0], latched at START. The address increment is STRIDE, zero-extended to AW. STRIDE=0 repeats BASE. Wrap is still modulo 2^AW.
- When undefined: no STRIDE port; the increment is fixed at 1.

Decomposition:
- Package mem_seq_pkg:
  - op_t enum (OP_VLOAD=2'b00, OP_XLOAD=2'b01, OP_VSTORE=2'b10, OP_BSTORE=2'b11)
  - state_t enum (S_IDLE, S_LOAD, S_DRAIN, S_STORE, S_DONE)
  - AW/DW/LW default localparams
- Sub-module mem_seq_addr_gen holds the address register, increment (stride under the macro) and remaining-count down-counter. Ports: load, advance, last flag.

Test Plan:
- Vector load, OP=00, BASE=0x00010, LEN=4, memory preloaded 0xA0..0xA3:
  - M_A=0x10..0x13 on 4 consecutive cycles
  - RVALID on the following 4 cycles with RDATA 0xA0..0xA3
  - DONE pulses 1 cycle after the last RVALID
- Vector store, OP=10, BASE=0x00100, LEN=3, WVALID pattern 1,0,1,1:
  - writes 0x100, 0x101, 0x102 only on valid cycles
  - M_WE=0 in the gap cycle
  - DONE one cycle after the third beat
- Byte-lane store, OP=11, LANE=2, WDATA=0x5A, LEN=1, address pre-holding 0x11223344:
  - M_E=1, M_POS=2, M_WDS=0x5A
  - read back gives 0x115A3344
- Extract load, OP=01, LANE=3, word 0xDEADBEEF:
  - M_E=1, M_S=1, RDATA=0x000000DE
- Boundaries:
  - LEN=0: DONE the cycle after START, no M_WE and no RVALID.
  - BASE=0x1FFFE, LEN=3: addresses 0x1FFFE, 0x1FFFF, 0x00000.
  - START while BUSY is ignored.
- Reset mid-burst: RST asserted during cycle 2 of a LEN=8 store.
  - M_WE, BUSY, WREADY drop to 0 asynchronously.
  - After release the block sits in IDLE, no DONE pulse.
  - Under MEM_SEQ_STRIDE_EN: rerun the load with STRIDE=4 and check addresses 0x10, 0x14, 0x18, 0x1C.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and default sizes for the memory burst sequencer.
//   op_t    : burst operation encoding as it arrives on the OP input
//   state_t : sequencer control states
//   SEQ_AW / SEQ_DW / SEQ_LW : default address, data and length-counter widths
package mem_seq_pkg;

    localparam int SEQ_AW = 17;
    localparam int SEQ_DW = 32;
    localparam int SEQ_LW = 8;

    typedef enum logic [1:0] {
        OP_VLOAD  = 2'b00,
        OP_XLOAD  = 2'b01,
        OP_VSTORE = 2'b10,
        OP_BSTORE = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Byte-lane operations drive M_E and M_POS.
    function automatic logic op_is_lane(input op_t op);
        return (op == OP_XLOAD) || (op == OP_BSTORE);
    endfunction

endpackage

// File: rtl/mem_seq_addr_gen.sv
// Address register and remaining-beat down-counter for one burst.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture base_i / len_i (and stride_i when present)
//   advance_i    : one beat issued or accepted; step address, decrement count
//   addr_o       : current word address
//   last_o       : the current beat is the final one of the burst
// Build option MEM_SEQ_STRIDE_EN adds stride_i; the address then steps by the
// zero-extended stride instead of 1. Address arithmetic wraps modulo 2^AW.
module mem_seq_addr_gen #(
    parameter int AW = 17,
    parameter int LW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic [LW-1:0] len_i,
`ifdef MEM_SEQ_STRIDE_EN
    input  logic [LW-1:0] stride_i,
`endif
    input  logic          advance_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [AW-1:0] inc_s;

`ifdef MEM_SEQ_STRIDE_EN
    logic [LW-1:0] stride_q, stride_d;

    assign inc_s = {{(AW-LW){1'b0}}, stride_q};

    // Stride is captured together with the base address.
    always_comb begin
        stride_d = stride_q;
        if (load_i) begin
            stride_d = stride_i;
        end else begin
            stride_d = stride_q;
        end
    end

    // Stride register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stride_q <= {LW{1'b0}};
        end else begin
            stride_q <= stride_d;
        end
    end
`else
    assign inc_s = {{(AW-1){1'b0}}, 1'b1};
`endif

    // Load takes priority over advance; both are never asserted together.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = base_i;
            rem_d  = len_i;
        end else if (advance_i) begin
            addr_d = addr_q + inc_s;
            rem_d  = rem_q - {{(LW-1){1'b0}}, 1'b1};
        end else begin
            addr_d = addr_q;
            rem_d  = rem_q;
        end
    end

    // Address and remaining-count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= {AW{1'b0}};
            rem_q  <= {LW{1'b0}};
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == {{(LW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mem_burst_sequencer.sv
// Burst sequencer between the vector datapath and the 32-bit data memory.
// A START in IDLE latches OP/BASE/LEN/LANE and moves LEN consecutive words,
// one per cycle, without further control from the decoder.
//   Request : CLK, RST (async active-high), START, OP, BASE, LEN, LANE
//   Store   : WVALID, WDATA in; WREADY out (high for the whole store burst)
//   Load    : RVALID, RDATA out (one cycle after each address, no backpressure)
//   Status  : BUSY (LOAD/DRAIN/STORE), DONE (one-cycle pulse at burst end)
//   Memory  : M_A, M_WDV, M_WDS, M_POS, M_WE, M_E, M_S out; M_RD in
// Build option MEM_SEQ_STRIDE_EN adds the STRIDE input (address step).
module mem_burst_sequencer
    import mem_seq_pkg::*;
#(
    parameter int AW = SEQ_AW,
    parameter int DW = SEQ_DW,
    parameter int LW = SEQ_LW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [1:0]    OP,
    input  logic [AW-1:0] BASE,
    input  logic [LW-1:0] LEN,
    input  logic [1:0]    LANE,
`ifdef MEM_SEQ_STRIDE_EN
    input  logic [LW-1:0] STRIDE,
`endif
    input  logic          WVALID,
    input  logic [DW-1:0] WDATA,
    output logic          WREADY,
    output logic          RVALID,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] M_A,
    output logic [DW-1:0] M_WDV,
    output logic [DW-1:0] M_WDS,
    output logic [1:0]    M_POS,
    output logic          M_WE,
    output logic          M_E,
    output logic          M_S,
    input  logic [DW-1:0] M_RD
);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          ag_load_s;
    logic          ag_adv_s;
    logic          ag_last_s;
    logic [AW-1:0] ag_addr_s;
    logic          busy_s;
    logic          store_s;
    logic          lane_op_s;

    mem_seq_addr_gen #(
        .AW(AW),
        .LW(LW)
    ) u_addr_gen (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (ag_load_s),
        .base_i   (BASE),
        .len_i    (LEN),
`ifdef MEM_SEQ_STRIDE_EN
        .stride_i (STRIDE),
`endif
        .advance_i(ag_adv_s),
        .addr_o   (ag_addr_s),
        .last_o   (ag_last_s)
    );

    // Next-state logic: request capture, beat issue and burst termination.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        lane_d    = lane_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        ag_load_s = 1'b0;
        ag_adv_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d      = op_t'(OP);
                    lane_d    = LANE;
                    ag_load_s = 1'b1;
                    if (LEN == {LW{1'b0}}) begin
                        state_d = S_DONE;
                    end else if (OP[1]) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // Memory answers in the same cycle; the word is presented
                // on RDATA one cycle later.
                ag_adv_s = 1'b1;
                rvalid_d = 1'b1;
                rdata_d  = M_RD;
                if (ag_last_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_STORE: begin
                // WVALID gaps stall the burst without writing.
                if (WVALID) begin
                    ag_adv_s = 1'b1;
                    if (ag_last_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STORE;
                    end
                end else begin
                    state_d = S_STORE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and read-return registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            op_q     <= OP_VLOAD;
            lane_q   <= 2'b00;
            rvalid_q <= 1'b0;
            rdata_q  <= {DW{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy_s    = (state_q == S_LOAD) || (state_q == S_DRAIN) || (state_q == S_STORE);
    assign store_s   = (state_q == S_STORE);
    assign lane_op_s = op_is_lane(op_q);

    assign BUSY   = busy_s;
    assign DONE   = (state_q == S_DONE);
    assign WREADY = store_s;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;

    // Write enable follows WVALID directly so a beat is written the cycle it is offered.
    assign M_WE  = store_s & WVALID;
    assign M_A   = ag_addr_s;
    assign M_E   = busy_s & lane_op_s;
    assign M_S   = busy_s & (op_q == OP_XLOAD);
    assign M_POS = (busy_s && lane_op_s) ? lane_q : 2'b00;
    assign M_WDV = store_s ? WDATA : {DW{1'b0}};
    assign M_WDS = (store_s && (op_q == OP_BSTORE)) ? WDATA : {DW{1'b0}};

endmodule

// File: tb/tb_mem_burst_sequencer.sv
module tb_mem_burst_sequencer;

    localparam int AW   = 17;
    localparam int DW   = 32;
    localparam int LW   = 8;
    localparam int MASK = 32'h1FFFF;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          lane;
        logic [1:0]    pos;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [1:0]    OP = 2'b00;
    logic [AW-1:0] BASE = '0;
    logic [LW-1:0] LEN = '0;
    logic [1:0]    LANE = 2'b00;
`ifdef MEM_SEQ_STRIDE_EN
    logic [LW-1:0] STRIDE = 8'd1;
`endif
    logic          WVALID = 1'b0;
    logic [DW-1:0] WDATA = '0;
    logic          WREADY, RVALID, BUSY, DONE, M_WE, M_E, M_S;
    logic [DW-1:0] RDATA, M_WDV, M_WDS, M_RD;
    logic [AW-1:0] M_A;
    logic [1:0]    M_POS;

    int errors = 0;
    int checks = 0;

    // Environment memory (driven by DUT writes and bench pokes) and reference copy.
    logic [DW-1:0] mem     [0:131071];
    logic [DW-1:0] ref_mem [0:131071];
    bit            mem_ready = 1'b0;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [DW-1:0] poke_d = '0;

    logic [DW-1:0] exp_rd[$];
    wr_t           exp_wr[$];
    logic [1:0]    cur_op = 2'b00;
    logic [1:0]    cur_lane = 2'b00;

    always #5 CLK = ~CLK;

    mem_burst_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .BASE(BASE), .LEN(LEN), .LANE(LANE),
`ifdef MEM_SEQ_STRIDE_EN
        .STRIDE(STRIDE),
`endif
        .WVALID(WVALID), .WDATA(WDATA), .WREADY(WREADY), .RVALID(RVALID), .RDATA(RDATA),
        .BUSY(BUSY), .DONE(DONE), .M_A(M_A), .M_WDV(M_WDV), .M_WDS(M_WDS), .M_POS(M_POS),
        .M_WE(M_WE), .M_E(M_E), .M_S(M_S), .M_RD(M_RD)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (i * 32'h9E3779B1) + 32'h01234567;
    endfunction

    // Memory read: zero-extended byte for extract loads, full word otherwise.
    assign M_RD = (M_E && M_S) ? ((mem[M_A] >> {M_POS, 3'b000}) & 32'h000000FF) : mem[M_A];

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 131072; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (poke_en) begin
            mem[poke_a] <= poke_d;
        end else if (M_WE) begin
            if (M_E) mem[M_A][{M_POS, 3'b000} +: 8] <= M_WDS[7:0];
            else     mem[M_A] <= M_WDV;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data or a write.
    logic [DW-1:0] mon_rd;
    wr_t           mon_wr;
    always @(negedge CLK) begin
        if (!RST && mem_ready) begin
            if (RVALID) begin
                if (exp_rd.size() == 0) begin
                    chk("rvalid_unexpected", {31'd0, RVALID}, 32'd0);
                end else begin
                    mon_rd = exp_rd.pop_front();
                    chk("rdata", RDATA, mon_rd);
                end
            end
            if (M_WE) begin
                if (exp_wr.size() == 0) begin
                    chk("write_unexpected", {31'd0, M_WE}, 32'd0);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    chk("wr_addr", {15'd0, M_A}, {15'd0, mon_wr.a});
                    chk("wr_wdv", M_WDV, mon_wr.d);
                    chk("wr_e", {31'd0, M_E}, {31'd0, mon_wr.lane});
                    if (mon_wr.lane) begin
                        chk("wr_wds", M_WDS, mon_wr.d);
                        chk("wr_pos", {30'd0, M_POS}, {30'd0, mon_wr.pos});
                    end
                end
            end
            if (BUSY) begin
                chk("busy_m_e", {31'd0, M_E}, {31'd0, cur_op[0]});
                chk("busy_m_s", {31'd0, M_S}, {31'd0, (cur_op == 2'b01)});
                chk("busy_wready", {31'd0, WREADY}, {31'd0, cur_op[1]});
                if (cur_op[0]) chk("busy_m_pos", {30'd0, M_POS}, {30'd0, cur_lane});
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        poke_en = 1'b1; poke_a = a[AW-1:0]; poke_d = d;
        ref_mem[a] = d;
        @(posedge CLK); #2;
        poke_en = 1'b0;
    endtask

    // One burst: expected read words / writes go to the scoreboard as stimulus is issued.
    task automatic do_burst(input logic [1:0] op, input int base, input int len, input logic [1:0] lane,
                            input int stride, input bit inject, input bit use_pat,
                            input logic [31:0] wpat, input bit use_fix, input logic [31:0] wfix);
        int st, n, beats, gaps, a, exp_n;
        bit seen;
        logic wv;
        logic [DW-1:0] wd, w;
        wr_t e;
`ifdef MEM_SEQ_STRIDE_EN
        st = stride;
`else
        st = 1;
`endif
        cur_op = op;
        cur_lane = lane;
        if (!op[1]) begin
            for (int i = 0; i < len; i++) begin
                a = (base + i * st) & MASK;
                w = ref_mem[a];
                exp_rd.push_back(op[0] ? ((w >> (lane * 8)) & 32'h000000FF) : w);
            end
        end
        START = 1'b1; OP = op; BASE = base[AW-1:0]; LEN = len[LW-1:0]; LANE = lane;
`ifdef MEM_SEQ_STRIDE_EN
        STRIDE = st[LW-1:0];
`endif
        @(posedge CLK); #2;
        START = 1'b0;
        n = 1; beats = 0; gaps = 0; seen = 1'b0;
        while (n <= 300) begin
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            if (op[1]) begin
                if (beats < len) begin
                    wv = use_pat ? wpat[(n - 1) % 32] : ($urandom_range(0, 3) != 0);
                    wd = use_fix ? wfix : $urandom;
                    WVALID = wv; WDATA = wd;
                    if (wv) begin
                        a = (base + beats * st) & MASK;
                        e.a = a[AW-1:0]; e.d = wd; e.lane = op[0]; e.pos = lane;
                        exp_wr.push_back(e);
                        if (op[0]) ref_mem[a][lane * 8 +: 8] = wd[7:0];
                        else       ref_mem[a] = wd;
                        beats++;
                    end else begin
                        gaps++;
                    end
                end else begin
                    WVALID = 1'b0;
                end
            end
            if (inject && n == 2) begin
                START = 1'b1; OP = ~op; BASE = $urandom; LEN = 8'd5; LANE = ~lane;
            end
            @(posedge CLK); #2;
            START = 1'b0;
            n++;
        end
        WVALID = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        exp_n = (len == 0) ? 1 : (op[1] ? len + gaps + 1 : len + 2);
        chk("done_latency", n, exp_n);
        // A START in the DONE cycle must be ignored.
        START = 1'b1; OP = 2'b10; LEN = 8'd3; BASE = $urandom;
        @(posedge CLK); #2;
        START = 1'b0;
        chk("idle_after_done_busy", {31'd0, BUSY}, 32'd0);
        chk("done_single_cycle", {31'd0, DONE}, 32'd0);
        chk("rd_queue_empty", exp_rd.size(), 32'd0);
        chk("wr_queue_empty", exp_wr.size(), 32'd0);
    endtask

    initial begin
        int b;
        logic [DW-1:0] d0;
        wr_t e;
        for (int i = 0; i < 131072; i++) ref_mem[i] = init_word(i);
        #3;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_we", {31'd0, M_WE}, 32'd0);
        chk("rst_wready", {31'd0, WREADY}, 32'd0);
        chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_me_ms_pos", {28'd0, M_E, M_S, M_POS}, 32'd0);
        chk("rst_m_a", {15'd0, M_A}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_wdv_wds", M_WDV | M_WDS, 32'd0);
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK); #2;

        // Vector load of preloaded words.
        for (int i = 0; i < 4; i++) poke(32'h10 + i, 32'hA0 + i);
        do_burst(2'b00, 32'h10, 4, 2'b00, 1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        // Vector store with a one-cycle WVALID gap (pattern 1,0,1,1).
        do_burst(2'b10, 32'h100, 3, 2'b00, 1, 1'b0, 1'b1, 32'b1101, 1'b0, 32'd0);
        // Byte-lane store into a known word, then read it back.
        poke(32'h300, 32'h11223344);
        do_burst(2'b11, 32'h300, 1, 2'd2, 1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h5A);
        chk("byte_merge", mem[17'h300], 32'h115A3344);
        do_burst(2'b00, 32'h300, 1, 2'b00, 1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        // Extract load of the top byte.
        poke(32'h400, 32'hDEADBEEF);
        do_burst(2'b01, 32'h400, 1, 2'd3, 1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        // Zero-length bursts.
        do_burst(2'b00, 32'h500, 0, 2'b00, 1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        do_burst(2'b10, 32'h500, 0, 2'b00, 1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'd0);
        // Address wrap at the top of the space.
        do_burst(2'b00, 32'h1FFFE, 3, 2'b00, 1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        // START while busy is ignored.
        do_burst(2'b00, 32'h600, 6, 2'b00, 1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        do_burst(2'b10, 32'h700, 6, 2'b00, 1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef MEM_SEQ_STRIDE_EN
        do_burst(2'b00, 32'h10, 4, 2'b00, 4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
`endif

        // Reset in cycle 2 of an 8-beat store: only the first beat lands.
        cur_op = 2'b10;
        START = 1'b1; OP = 2'b10; BASE = 17'h200; LEN = 8'd8; LANE = 2'b00;
`ifdef MEM_SEQ_STRIDE_EN
        STRIDE = 8'd1;
`endif
        @(posedge CLK); #2;
        START = 1'b0;
        d0 = $urandom;
        WVALID = 1'b1; WDATA = d0;
        e.a = 17'h200; e.d = d0; e.lane = 1'b0; e.pos = 2'b00;
        exp_wr.push_back(e);
        ref_mem[32'h200] = d0;
        @(posedge CLK); #1;
        WDATA = $urandom;
        RST = 1'b1;
        #1;
        chk("async_rst_we", {31'd0, M_WE}, 32'd0);
        chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("async_rst_wready", {31'd0, WREADY}, 32'd0);
        chk("async_rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_wr_queue", exp_wr.size(), 32'd0);
        exp_wr.delete();
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #2;
            chk("post_rst_done", {31'd0, DONE}, 32'd0);
            chk("post_rst_busy", {31'd0, BUSY}, 32'd0);
        end
        WVALID = 1'b0;
        do_burst(2'b00, 32'h200, 3, 2'b00, 1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Randomized bursts against the reference model.
        for (int k = 0; k < 40; k++) begin
            b = ($urandom_range(0, 3) == 0) ? (32'h1FFF8 + $urandom_range(0, 7)) : ($urandom & MASK);
            do_burst(2'($urandom_range(0, 3)), b, $urandom_range(0, 12), 2'($urandom_range(0, 3)),
                     $urandom_range(0, 7), ($urandom_range(0, 3) == 0), 1'b0, 32'd0, 1'b0, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
